// File: rtl/had_pkg.sv
// Shared HAD definitions: trace-counter FSM state encoding and default counter width.
package had_pkg;

   localparam int unsigned HAD_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      REQ   = 2'd2,
      DEBUG = 2'd3
   } had_state_e;

endpackage

// File: rtl/had_trace_cnt_dec.sv
// Saturating trace down-counter with a reload copy; write beats reload beats decrement.
module had_trace_cnt_dec
   import had_pkg::*;
#(
   parameter int unsigned CNT_W = HAD_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wen_i,
   input  logic [CNT_W-1:0] wdata_i,
   input  logic             dec_i,
   input  logic             reload_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] rld_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rld_q, rld_d;

   always_comb begin
      cnt_d = cnt_q;
      rld_d = rld_q;
      if (wen_i) begin
         cnt_d = wdata_i;
         rld_d = wdata_i;
      end else if (reload_i) begin
         cnt_d = rld_q;
      end else if (dec_i) begin
         // saturate at zero so a programmed 0 never wraps
         cnt_d = (cnt_q > CNT_W'(1)) ? cnt_q - CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         rld_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         rld_q <= rld_d;
      end
   end

   assign cnt_o = cnt_q;
   assign rld_o = rld_q;

endmodule

// File: rtl/had_trace_cnt.sv
// HAD trace-counter controller: arms trace mode, counts qualified retires, requests debug on expiry.
// Counter readback is enabled by defining HAD_TRACE_CNT_RB_EN; otherwise trace_cnt_rdata reads 0.
module had_trace_cnt
   import had_pkg::*;
#(
   parameter int unsigned CNT_W = HAD_CNT_W
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             regs_trace_en,
   input  logic             regs_cnt_wen,
   input  logic [CNT_W-1:0] regs_cnt_wdata,
   input  logic             trace_inst_vld,
   input  logic             iu_yy_xx_dbgon,
   output logic             trace_en_o,
   output logic             had_core_dbg_mode_req,
   output logic             trace_hit,
   output logic [CNT_W-1:0] trace_cnt_rdata
);

   had_state_e       state_q, state_d;
   logic             via_req_q, via_req_d;
   logic             hit_q, hit_d;
   logic             trace_en_q, trace_en_d;
   logic             req_q, req_d;
   logic             dec, reload, pulse, expire;
   logic [CNT_W-1:0] cnt, rld;

   had_trace_cnt_dec #(.CNT_W(CNT_W)) u_dec (
      .clk_i    (forever_cpuclk),
      .rst_i    (cpurst),
      .wen_i    (regs_cnt_wen),
      .wdata_i  (regs_cnt_wdata),
      .dec_i    (dec),
      .reload_i (reload),
      .cnt_o    (cnt),
      .rld_o    (rld)
   );

   // a same-cycle write swallows the retire pulse entirely
   assign pulse  = trace_inst_vld & ~regs_cnt_wen;
   assign expire = (cnt <= CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      via_req_d = via_req_q;
      hit_d     = hit_q;
      dec       = 1'b0;
      reload    = 1'b0;
      case (state_q)
         IDLE: begin
            if (regs_trace_en && !iu_yy_xx_dbgon) state_d = COUNT;
         end
         COUNT: begin
            if (!regs_trace_en) begin
               state_d = IDLE;
            end else if (iu_yy_xx_dbgon) begin
               state_d   = DEBUG;
               via_req_d = 1'b0;
            end else if (pulse) begin
               dec = 1'b1;
               if (expire) begin
                  state_d = REQ;
                  hit_d   = 1'b1;
               end
            end
         end
         REQ: begin
            if (iu_yy_xx_dbgon) begin
               state_d   = DEBUG;
               via_req_d = 1'b1;
            end
         end
         DEBUG: begin
            if (!iu_yy_xx_dbgon) begin
               state_d   = IDLE;
               reload    = via_req_q;
               via_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (regs_cnt_wen) hit_d = 1'b0;
      trace_en_d = (state_d == COUNT);
      req_d      = (state_d == REQ);
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q    <= IDLE;
         via_req_q  <= 1'b0;
         hit_q      <= 1'b0;
         trace_en_q <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         via_req_q  <= via_req_d;
         hit_q      <= hit_d;
         trace_en_q <= trace_en_d;
         req_q      <= req_d;
      end
   end

   assign trace_en_o            = trace_en_q;
   assign had_core_dbg_mode_req = req_q;
   assign trace_hit             = hit_q;

`ifdef HAD_TRACE_CNT_RB_EN
   assign trace_cnt_rdata = cnt;
`else
   assign trace_cnt_rdata = '0;
`endif

endmodule

// File: tb/tb_had_trace_cnt.sv
// Directed bench for had_trace_cnt with hand-computed expectations.
module tb_had_trace_cnt;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, wen, vld, dbgon;
   logic [7:0] wdata;
   logic       ten, req, hit;
   logic [7:0] rdata;
   int         checks = 0;
   int         errors = 0;

   had_trace_cnt #(.CNT_W(8)) dut (
      .forever_cpuclk        (clk),
      .cpurst                (rst),
      .regs_trace_en         (en),
      .regs_cnt_wen          (wen),
      .regs_cnt_wdata        (wdata),
      .trace_inst_vld        (vld),
      .iu_yy_xx_dbgon        (dbgon),
      .trace_en_o            (ten),
      .had_core_dbg_mode_req (req),
      .trace_hit             (hit),
      .trace_cnt_rdata       (rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input logic [7:0] exp);
      check(tag, 32'(dut.cnt), 32'(exp));
`ifdef HAD_TRACE_CNT_RB_EN
      check({tag, "_rb"}, 32'(rdata), 32'(exp));
`else
      check({tag, "_rb"}, 32'(rdata), 32'd0);
`endif
   endtask

   task automatic chk_st(input string tag, input logic [1:0] exp);
      check(tag, 32'(dut.state_q), 32'(exp));
   endtask

   task automatic write(input logic [7:0] v);
      wen = 1'b1; wdata = v;
      tick();
      wen = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wen = 1'b0; vld = 1'b0; dbgon = 1'b0; wdata = '0;
      #1;
      check("rst_ten", 32'(ten), 0);
      check("rst_req", 32'(req), 0);
      check("rst_hit", 32'(hit), 0);
      chk_cnt("rst_cnt", 8'd0);
      chk_st("rst_state", 2'd0);
      tick(); tick();
      rst = 1'b0;

      // count of 3 expires on the third pulse, reload restores 3 after debug
      write(8'd3);
      chk_cnt("t1_wr", 8'd3);
      en = 1'b1;
      tick();
      check("t1_ten", 32'(ten), 1);
      chk_st("t1_count", 2'd1);
      vld = 1'b1;
      tick(); chk_cnt("t1_p1", 8'd2);
      tick(); chk_cnt("t1_p2", 8'd1);
      check("t1_noreq", 32'(req), 0);
      tick(); vld = 1'b0;
      check("t1_req", 32'(req), 1);
      check("t1_hit", 32'(hit), 1);
      check("t1_ten_off", 32'(ten), 0);
      chk_cnt("t1_zero", 8'd0);
      tick();
      check("t1_req_held", 32'(req), 1);
      dbgon = 1'b1;
      tick();
      check("t1_req_drop", 32'(req), 0);
      chk_st("t1_debug", 2'd3);
      en = 1'b0; dbgon = 1'b0;
      tick();
      chk_cnt("t1_reload", 8'd3);
      chk_st("t1_idle", 2'd0);
      check("t1_hit_sticky", 32'(hit), 1);

      // programmed 0 behaves as 1
      write(8'd0);
      check("t2_hit_clr", 32'(hit), 0);
      en = 1'b1;
      tick();
      vld = 1'b1;
      tick(); vld = 1'b0;
      check("t2_req", 32'(req), 1);
      chk_st("t2_req_st", 2'd2);
      dbgon = 1'b1;
      tick();
      en = 1'b0; dbgon = 1'b0;
      tick();
      chk_st("t2_idle", 2'd0);

      // write beats a same-cycle decrement
      en = 1'b1;
      write(8'd3);
      chk_st("t3_count", 2'd1);
      wen = 1'b1; wdata = 8'd5; vld = 1'b1;
      tick();
      wen = 1'b0; vld = 1'b0;
      chk_cnt("t3_cnt5", 8'd5);
      chk_st("t3_still_count", 2'd1);

      // disable beats the expiring pulse
      write(8'd1);
      en = 1'b0; vld = 1'b1;
      tick(); vld = 1'b0;
      check("t4_noreq", 32'(req), 0);
      chk_st("t4_idle", 2'd0);
      chk_cnt("t4_cnt1", 8'd1);
      tick();
      check("t4_noreq2", 32'(req), 0);

      // external debug entry: no request, no reload
      write(8'd4);
      en = 1'b1;
      tick();
      vld = 1'b1;
      tick(); tick(); vld = 1'b0;
      chk_cnt("t5_cnt2", 8'd2);
      dbgon = 1'b1;
      tick();
      chk_st("t5_debug", 2'd3);
      check("t5_noreq", 32'(req), 0);
      check("t5_ten", 32'(ten), 0);
      dbgon = 1'b0; en = 1'b0;
      tick();
      chk_st("t5_idle", 2'd0);
      chk_cnt("t5_cnt_kept", 8'd2);

      // asynchronous reset while requesting
      write(8'd1);
      en = 1'b1;
      tick();
      vld = 1'b1;
      tick(); vld = 1'b0;
      check("t6_req", 32'(req), 1);
      #2 rst = 1'b1;
      #1;
      check("t6_req_rst", 32'(req), 0);
      check("t6_ten_rst", 32'(ten), 0);
      check("t6_hit_rst", 32'(hit), 0);
      chk_cnt("t6_cnt_rst", 8'd0);
      chk_st("t6_idle", 2'd0);
      en = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
